mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 64, meaning the width of every request address.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 64, meaning the width of write data and read data.
REQ-003 The block SHALL have parameter MASK_WIDTH, default 8, meaning the write byte-mask width (one bit per byte).
REQ-004 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst  input  1  the reset, asynchronous and active-low.
REQ-006 The block SHALL have port imem_ift  Mem_ift.Slave  bundle  the core instruction-fetch port (read channels only).
REQ-007 The block SHALL have port dmem_ift  Mem_ift.Slave  bundle  the core load/store port (read and write channels).
REQ-008 The block SHALL have port mem_ift  Mem_ift.Master  bundle  the single port toward unified memory.

Function
REQ-009 A transfer on any channel SHALL occur only in a cycle where both its valid and its ready are high ("fire").
REQ-010 The FSM SHALL have exactly three states: IDLE, REQ and RESP.
REQ-011 In IDLE, the block SHALL select the source: dmem write, else dmem read, else imem read, checked in that order on the current-cycle valids.
REQ-012 In IDLE, only the selected request channel SHALL have ready=1; all other upstream request readies SHALL be 0.
REQ-013 On a selected request fire in IDLE, the block SHALL latch the source id, the kind (read/write), the address, the wdata and the wmask, then go to REQ.
REQ-014 In IDLE with no upstream request valid, the block SHALL stay in IDLE with all mem_ift request valids at 0.
REQ-015 In REQ, the block SHALL drive exactly one of mem_ift.r_request_valid or mem_ift.w_request_valid high from the latched kind, with bits taken from the latched registers only.
REQ-016 All upstream request readies SHALL be 0 in REQ and RESP.
REQ-017 In REQ, the block SHALL hold valid and bits stable until the mem fire, then go to RESP.
REQ-018 The minimum request latency SHALL be upstream fire at cycle N and mem request valid at cycle N+1.
REQ-019 In RESP, for the latched kind only, the block SHALL forward mem reply valid and rdata combinationally to the latched source and return that source's reply ready combinationally to mem.
REQ-020 In RESP, the reply valid toward the non-latched source SHALL be 0.
REQ-021 The block SHALL return from RESP to IDLE on the reply fire.
REQ-022 A new request SHALL be accepted no earlier than the cycle after the reply fire, so only one transaction is outstanding at a time.
REQ-023 imem_ift.w_request_ready and imem_ift.w_reply_valid SHALL be constant 0.
REQ-024 A mem reply arriving with valid high in IDLE or REQ SHALL be ignored (mem reply readies 0).
REQ-025 Address, data and mask SHALL pass with no width change and no alteration.

Reset
REQ-026 With rst low, the block SHALL immediately set the state to IDLE and clear all latched registers to 0.
REQ-027 With rst low, all mem_ift valids and readies SHALL be 0 and all upstream reply valids SHALL be 0.
REQ-028 An asserted rst in REQ or RESP SHALL drop the transaction silently, and the first cycle after rst deasserts SHALL be IDLE with no replay.

Verification
REQ-029 The bench SHALL cover an imem fetch: imem raddr=0x80000004 fires at cycle 0 -> mem raddr=0x80000004 valid at cycle 1; reply rdata=0x0000_0013_0000_0093 is delivered to imem only, then IDLE.
REQ-030 The bench SHALL cover a simultaneous request: imem read and dmem write (waddr=0x1000, wdata=0xDEAD, wmask=0x03) both valid in IDLE -> dmem is granted, imem ready=0 until after the w_reply fire, then imem is served.
REQ-031 The bench SHALL cover backpressure: mem r_request_ready held 0 for 5 cycles in REQ -> raddr and valid stay stable and upstream readies stay 0, with a single fire on the 6th cycle.
REQ-032 The bench SHALL cover reply backpressure: dmem r_reply_ready=0 for 3 cycles in RESP -> mem r_reply_ready=0 and the state stays RESP, and rdata=0x1234 is delivered when ready rises.
REQ-033 The bench SHALL cover reset mid-transaction: rst low during RESP -> all valids are 0 at once, and after release a spurious mem reply valid is ignored and the state is IDLE.
REQ-034 The bench SHALL cover back-to-back transfers: 100 random alternating imem and dmem transfers -> every reply reaches the correct source, in order, with one transaction outstanding.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Memory port bundle: read request/reply and write request/reply channels.
interface Mem_ift #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MASK_WIDTH = 8
);
    logic                  r_request_valid;
    logic                  r_request_ready;
    logic [ADDR_WIDTH-1:0] r_request_raddr;
    logic                  r_reply_valid;
    logic                  r_reply_ready;
    logic [DATA_WIDTH-1:0] r_reply_rdata;
    logic                  w_request_valid;
    logic                  w_request_ready;
    logic [ADDR_WIDTH-1:0] w_request_waddr;
    logic [DATA_WIDTH-1:0] w_request_wdata;
    logic [MASK_WIDTH-1:0] w_request_wmask;
    logic                  w_reply_valid;
    logic                  w_reply_ready;

    modport Master (
        output r_request_valid, r_request_raddr, r_reply_ready,
        output w_request_valid, w_request_waddr, w_request_wdata, w_request_wmask, w_reply_ready,
        input  r_request_ready, r_reply_valid, r_reply_rdata,
        input  w_request_ready, w_reply_valid
    );

    modport Slave (
        input  r_request_valid, r_request_raddr, r_reply_ready,
        input  w_request_valid, w_request_waddr, w_request_wdata, w_request_wmask, w_reply_ready,
        output r_request_ready, r_reply_valid, r_reply_rdata,
        output w_request_ready, w_reply_valid
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction-fetch and load/store ports onto one memory port,
// one transaction outstanding at a time (dmem write > dmem read > imem read).
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MASK_WIDTH = 8
) (
    input  logic   clk,
    input  logic   rst,
    Mem_ift.Slave  imem_ift,
    Mem_ift.Slave  dmem_ift,
    Mem_ift.Master mem_ift
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic SRC_IMEM = 1'b0;
    localparam logic SRC_DMEM = 1'b1;
    localparam logic KIND_RD  = 1'b0;
    localparam logic KIND_WR  = 1'b1;

    logic [1:0]            state_q, state_d;
    logic                  src_q, src_d;
    logic                  kind_q, kind_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [MASK_WIDTH-1:0] wmask_q, wmask_d;

    // State and latched request registers; reset drops any transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            src_q   <= 1'b0;
            kind_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            kind_q  <= kind_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    // Next state, request latching and handshake steering; everything idles low in reset.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        kind_d  = kind_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;

        imem_ift.r_request_ready = 1'b0;
        imem_ift.w_request_ready = 1'b0;
        imem_ift.r_reply_valid   = 1'b0;
        imem_ift.r_reply_rdata   = '0;
        imem_ift.w_reply_valid   = 1'b0;
        dmem_ift.r_request_ready = 1'b0;
        dmem_ift.w_request_ready = 1'b0;
        dmem_ift.r_reply_valid   = 1'b0;
        dmem_ift.r_reply_rdata   = '0;
        dmem_ift.w_reply_valid   = 1'b0;

        mem_ift.r_request_valid  = 1'b0;
        mem_ift.r_request_raddr  = addr_q;
        mem_ift.w_request_valid  = 1'b0;
        mem_ift.w_request_waddr  = addr_q;
        mem_ift.w_request_wdata  = wdata_q;
        mem_ift.w_request_wmask  = wmask_q;
        mem_ift.r_reply_ready    = 1'b0;
        mem_ift.w_reply_ready    = 1'b0;

        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (dmem_ift.w_request_valid) begin
                        dmem_ift.w_request_ready = 1'b1;
                        src_d   = SRC_DMEM;
                        kind_d  = KIND_WR;
                        addr_d  = dmem_ift.w_request_waddr;
                        wdata_d = dmem_ift.w_request_wdata;
                        wmask_d = dmem_ift.w_request_wmask;
                        state_d = REQ;
                    end else if (dmem_ift.r_request_valid) begin
                        dmem_ift.r_request_ready = 1'b1;
                        src_d   = SRC_DMEM;
                        kind_d  = KIND_RD;
                        addr_d  = dmem_ift.r_request_raddr;
                        wdata_d = '0;
                        wmask_d = '0;
                        state_d = REQ;
                    end else if (imem_ift.r_request_valid) begin
                        imem_ift.r_request_ready = 1'b1;
                        src_d   = SRC_IMEM;
                        kind_d  = KIND_RD;
                        addr_d  = imem_ift.r_request_raddr;
                        wdata_d = '0;
                        wmask_d = '0;
                        state_d = REQ;
                    end
                end
                REQ: begin
                    mem_ift.r_request_valid = (kind_q == KIND_RD);
                    mem_ift.w_request_valid = (kind_q == KIND_WR);
                    if ((kind_q == KIND_RD && mem_ift.r_request_ready) ||
                        (kind_q == KIND_WR && mem_ift.w_request_ready)) begin
                        state_d = RESP;
                    end
                end
                RESP: begin
                    if (kind_q == KIND_WR) begin
                        dmem_ift.w_reply_valid = mem_ift.w_reply_valid;
                        mem_ift.w_reply_ready  = dmem_ift.w_reply_ready;
                        if (mem_ift.w_reply_valid && dmem_ift.w_reply_ready) begin
                            state_d = IDLE;
                        end
                    end else if (src_q == SRC_DMEM) begin
                        dmem_ift.r_reply_valid = mem_ift.r_reply_valid;
                        dmem_ift.r_reply_rdata = mem_ift.r_reply_rdata;
                        mem_ift.r_reply_ready  = dmem_ift.r_reply_ready;
                        if (mem_ift.r_reply_valid && dmem_ift.r_reply_ready) begin
                            state_d = IDLE;
                        end
                    end else begin
                        imem_ift.r_reply_valid = mem_ift.r_reply_valid;
                        imem_ift.r_reply_rdata = mem_ift.r_reply_rdata;
                        mem_ift.r_reply_ready  = imem_ift.r_reply_ready;
                        if (mem_ift.r_reply_valid && imem_ift.r_reply_ready) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level priority model.
module tb_mem_arbiter;
    logic clk;
    logic rst_n;

    Mem_ift imem_if ();
    Mem_ift dmem_if ();
    Mem_ift mem_if ();

    mem_arbiter dut (
        .clk      (clk),
        .rst      (rst_n),
        .imem_ift (imem_if),
        .dmem_ift (dmem_if),
        .mem_ift  (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Pending upstream requests, held until granted.
    bit          p_ir, p_dr, p_dw;
    logic [63:0] ir_addr, dr_addr, dw_addr, dw_data;
    logic [7:0]  dw_mask;

    localparam int W_IR = 0;
    localparam int W_DR = 1;
    localparam int W_DW = 2;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_up();
        imem_if.r_request_valid = p_ir;
        imem_if.r_request_raddr = ir_addr;
        dmem_if.r_request_valid = p_dr;
        dmem_if.r_request_raddr = dr_addr;
        dmem_if.w_request_valid = p_dw;
        dmem_if.w_request_waddr = dw_addr;
        dmem_if.w_request_wdata = dw_data;
        dmem_if.w_request_wmask = dw_mask;
    endtask

    task automatic clear_mem_side();
        mem_if.r_request_ready = 1'b0;
        mem_if.w_request_ready = 1'b0;
        mem_if.r_reply_valid   = 1'b0;
        mem_if.w_reply_valid   = 1'b0;
        mem_if.r_reply_rdata   = '0;
        imem_if.r_reply_ready  = 1'b0;
        dmem_if.r_reply_ready  = 1'b0;
        dmem_if.w_reply_ready  = 1'b0;
    endtask

    function automatic logic [3:0] up_rdys();
        return {imem_if.r_request_ready, imem_if.w_request_ready,
                dmem_if.r_request_ready, dmem_if.w_request_ready};
    endfunction

    // One full transaction from the current pending set, checked cycle by cycle.
    task automatic run_txn(input logic [63:0] rdata, input int req_stall,
                           input int rsp_delay, input int up_stall, input bit noise);
        int          w;
        bit          is_wr;
        logic [63:0] ea, ed;
        logic [7:0]  em;
        logic [2:0]  urdy;
        bit          mv;

        drive_up();
        #1;
        w     = p_dw ? W_DW : (p_dr ? W_DR : W_IR);
        is_wr = (w == W_DW);
        ea    = (w == W_DW) ? dw_addr : ((w == W_DR) ? dr_addr : ir_addr);
        ed    = is_wr ? dw_data : 64'h0;
        em    = is_wr ? dw_mask : 8'h0;
        chk("gnt_dw", dmem_if.w_request_ready, w == W_DW);
        chk("gnt_dr", dmem_if.r_request_ready, w == W_DR);
        chk("gnt_ir", imem_if.r_request_ready, w == W_IR);
        chk("gnt_iw", imem_if.w_request_ready, 0);
        chk("idle_mreq", {mem_if.r_request_valid, mem_if.w_request_valid}, 0);
        tick();

        if (w == W_DW) p_dw = 0;
        else if (w == W_DR) p_dr = 0;
        else p_ir = 0;
        drive_up();

        // Request phase: hold until the mem side accepts.
        for (int c = 0; c <= req_stall; c++) begin
            if (is_wr) begin
                mem_if.w_request_ready = (c == req_stall);
                mem_if.r_request_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
                mem_if.r_request_ready = (c == req_stall);
                mem_if.w_request_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            mem_if.r_reply_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_if.w_reply_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            imem_if.r_reply_ready = 1'b1;
            dmem_if.r_reply_ready = 1'b1;
            dmem_if.w_reply_ready = 1'b1;
            #1;
            chk("req_rvalid", mem_if.r_request_valid, !is_wr);
            chk("req_wvalid", mem_if.w_request_valid, is_wr);
            chk("req_addr", is_wr ? mem_if.w_request_waddr : mem_if.r_request_raddr, ea);
            if (is_wr) begin
                chk("req_wdata", mem_if.w_request_wdata, ed);
                chk("req_wmask", mem_if.w_request_wmask, em);
            end
            chk("req_uprdy", up_rdys(), 0);
            chk("req_rsprdy", {mem_if.r_reply_ready, mem_if.w_reply_ready}, 0);
            chk("req_upvld", {imem_if.r_reply_valid, imem_if.w_reply_valid,
                              dmem_if.r_reply_valid, dmem_if.w_reply_valid}, 0);
            tick();
        end
        clear_mem_side();

        // Reply phase: mem valid after rsp_delay, upstream ready after up_stall more.
        for (int c = 0; c <= rsp_delay + up_stall; c++) begin
            mv   = (c >= rsp_delay);
            urdy = noise ? 3'($urandom_range(0, 7)) : 3'b000;
            if (mv) urdy[w] = (c == rsp_delay + up_stall);
            if (is_wr) begin
                mem_if.w_reply_valid = mv;
                mem_if.r_reply_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_if.r_reply_rdata = {$urandom, $urandom};
            end else begin
                mem_if.r_reply_valid = mv;
                mem_if.w_reply_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_if.r_reply_rdata = rdata;
            end
            imem_if.r_reply_ready = urdy[0];
            dmem_if.r_reply_ready = urdy[1];
            dmem_if.w_reply_ready = urdy[2];
            #1;
            chk("rsp_ir_vld", imem_if.r_reply_valid, (w == W_IR) && mv);
            chk("rsp_dr_vld", dmem_if.r_reply_valid, (w == W_DR) && mv);
            chk("rsp_dw_vld", dmem_if.w_reply_valid, (w == W_DW) && mv);
            chk("rsp_iw_vld", imem_if.w_reply_valid, 0);
            if (mv && w == W_IR) chk("rsp_ir_data", imem_if.r_reply_rdata, rdata);
            if (mv && w == W_DR) chk("rsp_dr_data", dmem_if.r_reply_rdata, rdata);
            chk("rsp_mrrdy", mem_if.r_reply_ready, is_wr ? 1'b0 : urdy[w]);
            chk("rsp_mwrdy", mem_if.w_reply_ready, is_wr ? urdy[2] : 1'b0);
            chk("rsp_uprdy", up_rdys(), 0);
            chk("rsp_mreq", {mem_if.r_request_valid, mem_if.w_request_valid}, 0);
            tick();
        end
        clear_mem_side();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;

        rst_n = 1'b0;
        p_ir = 0; p_dr = 0; p_dw = 0;
        ir_addr = '0; dr_addr = '0; dw_addr = '0; dw_data = '0; dw_mask = '0;
        imem_if.w_request_valid = 1'b0;
        imem_if.w_request_waddr = '0;
        imem_if.w_request_wdata = '0;
        imem_if.w_request_wmask = '0;
        imem_if.w_reply_ready   = 1'b0;
        drive_up();
        clear_mem_side();

        // Reset: everything low even with upstream/mem activity present.
        p_ir = 1; ir_addr = 64'h40;
        drive_up();
        mem_if.r_reply_valid = 1'b1;
        mem_if.w_reply_valid = 1'b1;
        imem_if.r_reply_ready = 1'b1;
        dmem_if.w_reply_ready = 1'b1;
        tick();
        chk("rst_mreq", {mem_if.r_request_valid, mem_if.w_request_valid}, 0);
        chk("rst_mrdy", {mem_if.r_reply_ready, mem_if.w_reply_ready}, 0);
        chk("rst_uprdy", up_rdys(), 0);
        chk("rst_upvld", {imem_if.r_reply_valid, imem_if.w_reply_valid,
                          dmem_if.r_reply_valid, dmem_if.w_reply_valid}, 0);
        tick();
        p_ir = 0;
        drive_up();
        clear_mem_side();
        rst_n = 1'b1;
        tick();

        // Instruction fetch with minimum latency.
        p_ir = 1; ir_addr = 64'h8000_0004;
        run_txn(64'h0000_0013_0000_0093, 0, 0, 0, 0);

        // Simultaneous imem read and dmem write: write first, then the fetch.
        p_ir = 1; ir_addr = 64'h8000_0008;
        p_dw = 1; dw_addr = 64'h1000; dw_data = 64'hDEAD; dw_mask = 8'h03;
        run_txn(64'h0, 0, 1, 1, 0);
        run_txn(64'h0000_0000_0000_0513, 0, 0, 0, 0);

        // Request backpressure: five stalled cycles, accepted on the sixth.
        p_dr = 1; dr_addr = 64'h2000;
        run_txn(64'h5555, 5, 0, 0, 0);

        // Reply backpressure from the load/store port.
        p_dr = 1; dr_addr = 64'h2008;
        run_txn(64'h1234, 0, 0, 3, 0);

        // Reset during the reply phase.
        p_ir = 1; ir_addr = 64'h8000_0100;
        drive_up();
        #1;
        chk("mid_gnt", imem_if.r_request_ready, 1);
        tick();
        p_ir = 0;
        drive_up();
        mem_if.r_request_ready = 1'b1;
        #1;
        chk("mid_req", mem_if.r_request_valid, 1);
        tick();
        mem_if.r_request_ready = 1'b0;
        mem_if.r_reply_valid   = 1'b1;
        mem_if.r_reply_rdata   = 64'hABCD;
        imem_if.r_reply_ready  = 1'b0;
        #1;
        chk("mid_rsp_vld", imem_if.r_reply_valid, 1);
        rst_n = 1'b0;
        imem_if.r_reply_ready = 1'b1;
        #1;
        chk("mid_rst_mreq", {mem_if.r_request_valid, mem_if.w_request_valid}, 0);
        chk("mid_rst_mrdy", {mem_if.r_reply_ready, mem_if.w_reply_ready}, 0);
        chk("mid_rst_upvld", {imem_if.r_reply_valid, dmem_if.r_reply_valid,
                              dmem_if.w_reply_valid}, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_mrdy", mem_if.r_reply_ready, 0);
        chk("post_rst_upvld", imem_if.r_reply_valid, 0);
        chk("post_rst_mreq", {mem_if.r_request_valid, mem_if.w_request_valid}, 0);
        tick();
        chk("post_rst_mrdy2", mem_if.r_reply_ready, 0);
        chk("post_rst_mreq2", {mem_if.r_request_valid, mem_if.w_request_valid}, 0);
        clear_mem_side();
        p_dw = 1; dw_addr = 64'h3000; dw_data = 64'h77; dw_mask = 8'hF0;
        run_txn(64'h0, 1, 0, 0, 0);

        // Random alternating traffic with extra contending requests and noise.
        for (int i = 0; i < 100; i++) begin
            if (!p_ir && !p_dr && !p_dw && $urandom_range(0, 3) == 0) begin
                drive_up();
                #1;
                chk("idle_empty_mreq", {mem_if.r_request_valid, mem_if.w_request_valid}, 0);
                chk("idle_empty_rdy", up_rdys(), 0);
                tick();
            end
            if (i % 2 == 0) begin
                if (!p_ir) begin p_ir = 1; ir_addr = {$urandom, $urandom}; end
            end else if ($urandom_range(0, 1) == 1) begin
                if (!p_dw) begin
                    p_dw = 1; dw_addr = {$urandom, $urandom};
                    dw_data = {$urandom, $urandom}; dw_mask = 8'($urandom);
                end
            end else begin
                if (!p_dr) begin p_dr = 1; dr_addr = {$urandom, $urandom}; end
            end
            if (!p_ir && $urandom_range(0, 3) == 0) begin p_ir = 1; ir_addr = {$urandom, $urandom}; end
            if (!p_dr && $urandom_range(0, 3) == 0) begin p_dr = 1; dr_addr = {$urandom, $urandom}; end
            rd = {$urandom, $urandom};
            run_txn(rd, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
